posit_unpack_stream: RTL and testbench

Streaming posit<32,2> decoder. It takes packed posits on a valid/ready input channel and emits unpacked fields (sign, combined regime/exponent scale, left-aligned fraction, zero and NaR flags) on a valid/ready output channel. The scale/fraction encoding is the same one the posit adders and multipliers consume. The block sits between memory/stream interfaces and the arithmetic pipelines, and is the decode counterpart of the adders' pack stage.

---
 rtl/posit_unpack_stream_if.sv | 38 +++
 rtl/posit_unpack_stream.sv | 190 +++++++++++++++++++
 tb/tb_posit_unpack_stream.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_unpack_stream_if.sv
// -----------------------------------------------------------------------------
// posit_unpack_stream_if
//   Valid/ready channels of the posit<32,2> stream decoder.
//
//   Input channel : in_valid, in_ready, in_posit
//   Output channel: out_valid, out_ready, out_sgn, out_scale, out_fraction,
//                   out_zero, out_inf
//
//   Modports:
//     master - producer of posits / consumer of decoded fields (stream source)
//     slave  - the decoder itself
// -----------------------------------------------------------------------------
interface posit_unpack_stream_if #(
  parameter int NBITS = 32,
  parameter int FBITS = 27
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_posit;

  logic             out_valid;
  logic             out_ready;
  logic             out_sgn;
  logic [7:0]       out_scale;
  logic [FBITS-1:0] out_fraction;
  logic             out_zero;
  logic             out_inf;

  modport master (
    output in_valid, in_posit, out_ready,
    input  in_ready, out_valid, out_sgn, out_scale, out_fraction, out_zero, out_inf
  );

  modport slave (
    input  in_valid, in_posit, out_ready,
    output in_ready, out_valid, out_sgn, out_scale, out_fraction, out_zero, out_inf
  );
endinterface

// File: rtl/posit_unpack_stream.sv
// -----------------------------------------------------------------------------
// posit_unpack_stream
//   Streaming posit<32,2> decoder. Packed posits arrive on a valid/ready
//   channel; sign, combined scale (4*k + exp), MSB-aligned fraction (hidden
//   bit excluded) and zero/NaR flags leave on a second valid/ready channel.
//
//   Pipeline:
//     S1 - sign, zero/NaR flags, 31-bit magnitude of the body
//     S2 - regime run decode, scale and fraction; drives the outputs
//
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - asynchronous active-low reset; drops every in-flight item
//     bus    - posit_unpack_stream_if.slave (both stream channels)
//
//   Build option:
//     POSIT_UNPACK_SKID_EN - inserts a 2-entry skid FIFO ahead of S1 so that
//     in_ready is a register with no path from out_ready (latency 3 instead
//     of 2, throughput unchanged).
// -----------------------------------------------------------------------------
module posit_unpack_stream #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int FBITS = NBITS - 3 - ES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  posit_unpack_stream_if.slave  bus
);

  localparam int AW   = NBITS - 1;    // magnitude width (sign stripped)
  localparam int BW   = ES + FBITS;   // exponent + fraction body width
  localparam int DROP = AW - BW;      // always-zero tail after the shift

  typedef struct packed {
    logic          sgn;
    logic          zero;
    logic          inf;
    logic [AW-1:0] mag;
  } s1_t;

  // Length of the run of bits equal to the MSB, starting at the MSB.
  function automatic logic [5:0] lead_run(input logic [AW-1:0] a);
    logic       done;
    logic [5:0] n;
    n    = '0;
    done = 1'b0;
    for (int i = AW - 1; i >= 0; i--) begin
      if (!done && a[i] == a[AW-1]) n = n + 6'd1;
      else                          done = 1'b1;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage handshakes
  // ---------------------------------------------------------------------------
  logic             s1_valid, s2_valid;
  logic             s1_ready, s2_ready;
  logic             src_valid;
  logic [NBITS-1:0] src_posit;

  assign s2_ready = ~s2_valid | bus.out_ready;
  assign s1_ready = ~s1_valid | s2_ready;

`ifdef POSIT_UNPACK_SKID_EN
  // Two-entry FIFO; in_ready is registered from the next occupancy so the
  // upstream never sees out_ready combinationally.
  logic [NBITS-1:0] skid_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       skid_cnt, cnt_next;
  logic             in_ready_q;
  logic             push, pop;

  assign push      = bus.in_valid & in_ready_q;
  assign pop       = src_valid & s1_ready;
  assign src_valid = (skid_cnt != 2'd0);
  assign src_posit = skid_mem[rd_ptr];
  assign cnt_next  = skid_cnt + {1'b0, push} - {1'b0, pop};
  assign bus.in_ready = in_ready_q;

  // NOTE: payload storage has no reset; skid_cnt alone says which entries
  // hold live data, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) skid_mem[wr_ptr] <= bus.in_posit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      skid_cnt   <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      skid_cnt   <= cnt_next;
      in_ready_q <= (cnt_next != 2'd2);
    end
  end
`else
  assign src_valid    = bus.in_valid;
  assign src_posit    = bus.in_posit;
  assign bus.in_ready = s1_ready;
`endif

  // ---------------------------------------------------------------------------
  // S1: sign, special values, magnitude
  // ---------------------------------------------------------------------------
  s1_t s1_d, s1_q;

  always_comb begin
    s1_d.sgn  = src_posit[NBITS-1];
    s1_d.zero = (src_posit == '0);
    s1_d.inf  = (src_posit == {1'b1, {AW{1'b0}}});
    s1_d.mag  = src_posit[NBITS-1] ? (~src_posit[AW-1:0] + AW'(1)) : src_posit[AW-1:0];
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (s1_ready) s1_valid <= src_valid;
      // Payload only loads on a transfer, so an idle or X bus never leaks in.
      if (s1_ready && src_valid) s1_q <= s1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: regime / exponent / fraction decode
  // ---------------------------------------------------------------------------
  logic          regime;
  logic [5:0]    run_len, shamt;
  logic [BW-1:0] body;
  logic [7:0]    k, scale_d;
  logic [FBITS-1:0] frac_d;

  // NOTE: every variable is assigned before any conditional override, so no
  // path through this block leaves a value held (no latch).
  always_comb begin
    regime  = s1_q.mag[AW-1];
    run_len = lead_run(s1_q.mag);
    // Skip the regime run plus its terminator; a shift of 32 (run of 31,
    // no terminator) clears everything, giving the truncated exponent of 0.
    shamt   = run_len + 6'd1;
    body    = BW'((s1_q.mag << shamt) >> DROP);
    k       = regime ? (8'(run_len) - 8'd1) : (8'd0 - 8'(run_len));
    scale_d = (k << ES) + 8'(body[BW-1 -: ES]);
    frac_d  = body[FBITS-1:0];
    if (s1_q.zero || s1_q.inf) begin
      scale_d = '0;
      frac_d  = '0;
    end
  end

  logic             s2_sgn, s2_zero, s2_inf;
  logic [7:0]       s2_scale;
  logic [FBITS-1:0] s2_frac;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sgn   <= 1'b0;
      s2_zero  <= 1'b0;
      s2_inf   <= 1'b0;
      s2_scale <= '0;
      s2_frac  <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sgn   <= s1_q.sgn;
        s2_zero  <= s1_q.zero;
        s2_inf   <= s1_q.inf;
        s2_scale <= scale_d;
        s2_frac  <= frac_d;
      end
    end
  end

  assign bus.out_valid    = s2_valid;
  assign bus.out_sgn      = s2_sgn;
  assign bus.out_scale    = s2_scale;
  assign bus.out_fraction = s2_frac;
  assign bus.out_zero     = s2_zero;
  assign bus.out_inf      = s2_inf;

endmodule

// File: tb/tb_posit_unpack_stream.sv
// -----------------------------------------------------------------------------
// tb_posit_unpack_stream
//   Scoreboard bench for posit_unpack_stream. Accepted inputs push an
//   expected record (directed constant or a bit-walking reference decode);
//   output transfers pop and compare. Define POSIT_UNPACK_SKID_EN to match a
//   skid-enabled build.
// -----------------------------------------------------------------------------
module tb_posit_unpack_stream;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  posit_unpack_stream_if bus ();

  posit_unpack_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef POSIT_UNPACK_SKID_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic        sgn;
    logic [7:0]  scale;
    logic [26:0] frac;
    logic        zero;
    logic        inf;
  } res_t;

  res_t sb[$];
  res_t directed_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  res_t held;
  bit   held_valid    = 1'b0;
  bit   saw_out_valid = 1'b0;
  bit   saw_in_xfer   = 1'b0;
  bit   probe_ready   = 1'b0;

  function automatic res_t mk(input logic sgn, input int scale, input logic [26:0] frac,
                              input logic zero, input logic inf);
    res_t r;
    r.sgn = sgn; r.scale = 8'(scale); r.frac = frac; r.zero = zero; r.inf = inf;
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("sgn=%b scale=%0d frac=%h zero=%b inf=%b",
                     r.sgn, $signed(r.scale), r.frac, r.zero, r.inf);
  endfunction

  // Reference decode: walks the bits of the negated word one position at a time.
  function automatic res_t ref_decode(input logic [31:0] p);
    res_t       r;
    logic [31:0] v;
    logic       rb;
    int         pos, n, k, e;
    r = '0;
    if (p == 32'h0) begin r.zero = 1'b1; return r; end
    if (p == 32'h8000_0000) begin r.inf = 1'b1; r.sgn = 1'b1; return r; end
    r.sgn = p[31];
    v     = p[31] ? (~p + 32'd1) : p;
    rb    = v[30];
    pos   = 30;
    n     = 0;
    while (pos >= 0 && v[pos] == rb) begin n++; pos--; end
    k = rb ? n - 1 : -n;
    pos--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2 + ((pos >= 0) ? int'(v[pos]) : 0);
      pos--;
    end
    for (int j = 26; j >= 0; j--) begin
      r.frac[j] = (pos >= 0) ? v[pos] : 1'b0;
      pos--;
    end
    r.scale = 8'(4 * k + e);
    return r;
  endfunction

  function automatic res_t sample_out();
    res_t r;
    r.sgn = bus.out_sgn; r.scale = bus.out_scale; r.frac = bus.out_fraction;
    r.zero = bus.out_zero; r.inf = bus.out_inf;
    return r;
  endfunction

  // One clock: sample at the falling edge, score transfers, return at posedge+1.
  task automatic cycle();
    res_t cur, want;
    bit   ov, orr, iv, ir;
    @(negedge clk);
`ifdef POSIT_UNPACK_SKID_EN
    if (probe_ready) begin
      ir = bus.in_ready;
      bus.out_ready = ~bus.out_ready;
      #1;
      n_checks++;
      if (bus.in_ready !== ir) begin
        n_fail++;
        $display("FAIL in_ready_path: in_ready=%b after out_ready flip, was %b", bus.in_ready, ir);
      end
      bus.out_ready = ~bus.out_ready;
      #1;
    end
`endif
    cur = sample_out();
    ov  = bus.out_valid; orr = bus.out_ready;
    iv  = bus.in_valid;  ir  = bus.in_ready;
    if (held_valid) begin
      n_checks++;
      if (ov !== 1'b1 || cur !== held) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b %s, required valid=1 %s", ov, fmt(cur), fmt(held));
      end
    end
    held_valid    = ov & ~orr;
    held          = cur;
    saw_out_valid = ov;
    saw_in_xfer   = iv & ir;
    if (ov && orr) begin
      n_out++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: %s, required no output", fmt(cur));
      end else begin
        want = sb.pop_front();
        if (cur !== want) begin
          n_fail++;
          $display("FAIL decode: got %s, required %s", fmt(cur), fmt(want));
        end
      end
    end
    if (iv && ir) begin
      if (directed_q.size() > 0) sb.push_back(directed_q.pop_front());
      else                       sb.push_back(ref_decode(bus.in_posit));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] items[$], input int bound, output int used);
    int idx;
    idx  = 0;
    used = 0;
    while (idx < items.size() && used < bound) begin
      bus.in_valid = 1'b1;
      bus.in_posit = items[idx];
      cycle();
      used++;
      if (saw_in_xfer) idx++;
    end
    bus.in_valid = 1'b0;
    bus.in_posit = 'x;
    n_checks++;
    if (idx != items.size()) begin
      n_fail++;
      $display("FAIL send_timeout: accepted %0d, required %0d", idx, items.size());
    end
  endtask

  task automatic drain(input int bound);
    int cyc;
    cyc = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (sb.size() > 0 && cyc < bound) begin cycle(); cyc++; end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    repeat (4) cycle();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_posit = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || sample_out() !== res_t'(0)) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b %s, required all 0", bus.out_valid, fmt(sample_out()));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: in_ready=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] items[$];
    int lat, used;
    bus.out_ready = 1'b1;
    directed_q.push_back(mk(1'b0, 0, 27'h0, 1'b0, 1'b0));
    bus.in_valid = 1'b1; bus.in_posit = 32'h4000_0000;
    cycle();
    n_checks++;
    if (!saw_in_xfer) begin
      n_fail++;
      $display("FAIL basic_accept: in_ready=0 on idle pipeline, required 1");
    end
    bus.in_valid = 1'b0; bus.in_posit = 'x;
    lat = 0;
    do begin cycle(); lat++; end while (!saw_out_valid && lat < 10);
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL basic_latency: %0d cycles, required %0d", lat, LAT);
    end
    directed_q.push_back(mk(1'b0, 1, 27'h0, 1'b0, 1'b0));
    directed_q.push_back(mk(1'b0, 0, 27'h400_0000, 1'b0, 1'b0));
    items = '{32'h4800_0000, 32'h4400_0000};
    send(items, 20, used);
    drain(20);
  endtask

  task automatic test_sign_limits();
    logic [31:0] items[$];
    int used;
    directed_q.push_back(mk(1'b1, 0, 27'h0, 1'b0, 1'b0));
    directed_q.push_back(mk(1'b0, 120, 27'h0, 1'b0, 1'b0));
    directed_q.push_back(mk(1'b0, -120, 27'h0, 1'b0, 1'b0));
    items = '{32'hC000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
    bus.out_ready = 1'b1;
    send(items, 20, used);
    drain(20);
  endtask

  task automatic test_special();
    logic [31:0] items[$];
    int used;
    directed_q.push_back(mk(1'b0, 0, 27'h0, 1'b1, 1'b0));
    directed_q.push_back(mk(1'b1, 0, 27'h0, 1'b0, 1'b1));
    items = '{32'h0000_0000, 32'h8000_0000};
    bus.out_ready = 1'b1;
    send(items, 20, used);
    drain(20);
  endtask

  task automatic test_back_to_back();
    logic [31:0] items[$];
    int used, base, extra;
    items = '{32'h5A5A_1234, 32'hB00F_0001, 32'h0123_4567, 32'hF000_0ABC,
              32'h3FFF_0000, 32'h6ABC_DEF0};
    bus.out_ready = 1'b1;
    base = n_out;
    send(items, 40, used);
    n_checks++;
    if (used != items.size()) begin
      n_fail++;
      $display("FAIL b2b_input_rate: %0d cycles, required %0d", used, items.size());
    end
    extra = 0;
    while (n_out - base < items.size() && extra < 20) begin cycle(); extra++; end
    n_checks++;
    if (extra != LAT) begin
      n_fail++;
      $display("FAIL b2b_output_rate: tail %0d cycles, required %0d", extra, LAT);
    end
    drain(20);
  endtask

  task automatic test_backpressure();
    logic [31:0] items[8];
    int idx, cyc, base;
    foreach (items[i]) items[i] = $urandom >> $urandom_range(0, 12);
    idx = 0; cyc = 0; base = n_out;
    while ((idx < 8 || sb.size() > 0) && cyc < 200) begin
      bus.out_ready = !(cyc >= 3 && cyc < 8);
      bus.in_valid  = (idx < 8);
      bus.in_posit  = (idx < 8) ? items[idx] : 'x;
      cycle();
      if (saw_in_xfer) idx++;
      cyc++;
    end
    n_checks++;
    if (n_out - base != 8) begin
      n_fail++;
      $display("FAIL backpressure_count: %0d results, required 8", n_out - base);
    end
    drain(20);
  endtask

  task automatic test_reset_midstream();
    logic [31:0] items[$];
    int used, seen;
    bus.out_ready = 1'b0;
    items = '{32'h4000_0000, 32'h4400_0000};
    send(items, 20, used);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: out_valid=%b during reset, required 0", bus.out_valid);
    end
    sb.delete();
    directed_q.delete();
    held_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (6) begin cycle(); if (saw_out_valid) seen++; end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_flush: %0d outputs after reset, required 0", seen);
    end
    directed_q.push_back(mk(1'b0, 1, 27'h0, 1'b0, 1'b0));
    items = '{32'h4800_0000};
    send(items, 20, used);
    drain(20);
  endtask

  task automatic test_random();
    logic [31:0] corner[5];
    int sent, cyc, base;
    corner = '{32'h0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    sent = 0; cyc = 0; base = n_out;
    probe_ready = 1'b1;
    while ((sent < 3000 || sb.size() > 0) && cyc < 20000) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (sent < 3000 && $urandom_range(0, 9) < 7) begin
        bus.in_valid = 1'b1;
        if ($urandom_range(0, 15) == 0) bus.in_posit = corner[$urandom_range(0, 4)];
        else if ($urandom_range(0, 1) == 0) bus.in_posit = $urandom;
        else bus.in_posit = ($urandom >> $urandom_range(0, 31)) ^ ({32{$urandom_range(0, 1) == 1}});
      end else begin
        bus.in_valid = 1'b0;
        bus.in_posit = 'x;
      end
      cycle();
      if (saw_in_xfer) sent++;
      cyc++;
    end
    probe_ready  = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (sent != 3000 || n_out - base != 3000) begin
      n_fail++;
      $display("FAIL random_count: sent %0d got %0d, required 3000 each", sent, n_out - base);
    end
    drain(20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_limits();
    test_special();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
